// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE,
        WAIT_STOP
    } state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and derives edge and START/STOP strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Fewer than two stages would not protect against metastability.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_ff;
    logic [STAGES-1:0] sda_ff;
    logic              scl_d;
    logic              sda_d;
    logic              sda_rise;
    logic              sda_fall;

    // Synchronizer chains plus one extra sample for edge detection; reset to idle-bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[STAGES-2:0], scl_in};
            sda_ff <= {sda_ff[STAGES-2:0], sda_in};
            scl_d  <= scl_ff[STAGES-1];
            sda_d  <= sda_ff[STAGES-1];
        end
    end

    assign scl_s     = scl_ff[STAGES-1];
    assign sda_s     = sda_ff[STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign sda_rise  = sda_s & ~sda_d;
    assign sda_fall  = ~sda_s & sda_d;
    // scl must be high in both samples so an scl edge can never masquerade as a bus condition.
    assign start_det = sda_fall & scl_s & scl_d;
    assign stop_det  = sda_rise & scl_s & scl_d;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target: address match, byte writes with ACK, byte reads from data_in.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0101010,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        sda,
    input  logic       scl,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    logic       sda_oe;
    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;
    logic       ack_rx;

    // Open-drain: only ever pull low or release.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    // Protocol FSM: bus conditions override everything; data sampled on scl_rise, sda changed on scl_fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            rw       <= RW_WRITE;
            ack_rx   <= NACK;
            sda_oe   <= 1'b0;
            data_out <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == SLAVE_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shift[0];
                                state  <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw == RW_READ) begin
                                // bit_cnt counts bits already placed on the bus.
                                shift   <= {data_in[6:0], 1'b0};
                                sda_oe  <= ~data_in[7];
                                tx_req  <= 1'b1;
                                bit_cnt <= 4'd1;
                                state   <= RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                data_out <= {shift[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_rx <= sda_s;
                        end else if (scl_fall) begin
                            if (ack_rx == ACK) begin
                                shift   <= {data_in[6:0], 1'b0};
                                sda_oe  <= ~data_in[7];
                                tx_req  <= 1'b1;
                                bit_cnt <= 4'd1;
                                state   <= RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    IGNORE, WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench: bench-side I2C master, transaction-level scoreboard.
module tb_i2c_slave;

    localparam logic [6:0] ADDR = 7'b0101010;
    localparam int         Q    = 5;  // quarter bit period in clk cycles

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       scl      = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [7:0] data_in  = 8'h00;
    wire        sda;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR (ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sda     (sda),
        .scl     (scl),
        .data_in (data_in),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int rx_cycles = 0;
    int tx_cycles = 0;
    int overlap = 0;

    // Reference state, derived from transaction rules only.
    logic [7:0] exp_data_out = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) rx_cycles++;
        if (tx_req) tx_cycles++;
        if (rx_valid && tx_req) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic obs);
        wq(Q);
        m_sda_oe = ~b;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        obs = sda;
        wq(Q);
        scl = 1'b0;
    endtask

    task automatic do_start();
        wq(Q);
        m_sda_oe = 1'b0;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        m_sda_oe = 1'b1;
        wq(Q);
        scl = 1'b0;
    endtask

    task automatic do_stop();
        wq(Q);
        m_sda_oe = 1'b1;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        m_sda_oe = 1'b0;
        wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(b[i], o);
            if (b[i]) chk({tag, "_released"}, o, 1'b1);
        end
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, o);
            b[i] = o;
        end
    endtask

    task automatic xfer_write(input logic [7:0] addr_byte, input logic [7:0] bytes[$], input bit stop);
        logic ack;
        bit   match;
        int   rx0;
        match = (addr_byte[7:1] == ADDR);
        rx0   = rx_cycles;
        do_start();
        send_byte(addr_byte, "waddr", ack);
        chk("waddr_ack", ack, match ? 1'b0 : 1'b1);
        chk("busy_after_waddr", busy, match);
        foreach (bytes[k]) begin
            send_byte(bytes[k], "wdata", ack);
            chk("wdata_ack", ack, match ? 1'b0 : 1'b1);
            if (match) exp_data_out = bytes[k];
            chk("data_out", data_out, exp_data_out);
        end
        chk("rx_pulse_cycles", rx_cycles - rx0, match ? bytes.size() : 0);
        if (stop) begin
            do_stop();
            wq(4);
            chk("busy_after_stop", busy, 1'b0);
        end
    endtask

    task automatic xfer_read(input logic [7:0] addr_byte, input logic [7:0] bytes[$], input bit stop);
        logic       ack;
        logic       o;
        logic [7:0] got;
        bit         match;
        int         tx0;
        match   = (addr_byte[7:1] == ADDR);
        tx0     = tx_cycles;
        data_in = bytes[0];
        do_start();
        send_byte(addr_byte, "raddr", ack);
        chk("raddr_ack", ack, match ? 1'b0 : 1'b1);
        chk("busy_after_raddr", busy, match);
        for (int k = 0; k < bytes.size(); k++) begin
            recv_byte(got);
            chk("rdata", got, match ? bytes[k] : 8'hFF);
            if (k < bytes.size() - 1) begin
                data_in = bytes[k+1];
                bit_xfer(1'b0, o);
            end else begin
                bit_xfer(1'b1, o);
                chk("nack_slot_released", o, 1'b1);
            end
        end
        chk("tx_pulse_cycles", tx_cycles - tx0, match ? bytes.size() : 0);
        if (stop) begin
            do_stop();
            wq(4);
            chk("busy_after_stop", busy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic       ack;
        logic       o;
        int         rx0;

        wq(5);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sda", sda, 1'b1);
        reset = 1'b0;
        wq(5);

        // 1: basic write
        q = {};
        q.push_back(8'hAA);
        xfer_write(8'h54, q, 1'b1);

        // 2: address mismatch
        q = {};
        q.push_back(8'h11);
        xfer_write(8'h56, q, 1'b1);

        // 3: single read, NACK
        q = {};
        q.push_back(8'h3C);
        xfer_read(8'h55, q, 1'b1);

        // 4: two-byte read
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'h5A);
        xfer_read(8'h55, q, 1'b1);

        // randomized writes and reads
        for (int t = 0; t < 3; t++) begin
            q = {};
            for (int n = $urandom_range(1, 3); n > 0; n--) q.push_back(8'($urandom));
            xfer_write(8'h54, q, 1'b1);
            q = {};
            for (int n = $urandom_range(1, 3); n > 0; n--) q.push_back(8'($urandom));
            xfer_read(8'h55, q, 1'b1);
        end
        q = {};
        q.push_back(8'($urandom));
        xfer_write({7'(ADDR ^ 7'(($urandom_range(1, 127)))), 1'b0}, q, 1'b1);

        // 5: write then repeated START into a read
        q = {};
        q.push_back(8'h01);
        xfer_write(8'h54, q, 1'b0);
        chk("data_out_before_sr", data_out, 8'h01);
        q = {};
        q.push_back(8'($urandom));
        xfer_read(8'h55, q, 1'b1);

        // 6a: reset while the address ACK is being driven
        do_start();
        for (int i = 7; i >= 0; i--) bit_xfer(q[0][i] | 1'b1 ? logic'((8'h54 >> i) & 1) : 1'b0, o);
        m_sda_oe = 1'b0;
        wq(Q);
        chk("ack_driven_before_reset", sda, 1'b0);
        reset = 1'b1;
        wq(1);
        reset = 1'b0;
        chk("sda_released_after_reset", sda, 1'b1);
        chk("busy_after_reset", busy, 1'b0);
        wq(Q - 1);
        scl = 1'b1;
        wq(2 * Q);
        scl = 1'b0;
        do_stop();

        // 6b: reset during bit 4 of a write data byte
        rx0 = rx_cycles;
        do_start();
        send_byte(8'h54, "r6addr", ack);
        chk("r6_addr_ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, o);
        wq(Q);
        m_sda_oe = 1'b0;
        reset = 1'b1;
        wq(1);
        reset = 1'b0;
        chk("r6_busy", busy, 1'b0);
        chk("r6_sda", sda, 1'b1);
        wq(Q - 1);
        scl = 1'b1;
        wq(2 * Q);
        scl = 1'b0;
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, o);
        bit_xfer(1'b1, ack);
        chk("r6_ignored_ack", ack, 1'b1);
        chk("r6_no_rx", rx_cycles - rx0, 0);
        exp_data_out = 8'h00;
        chk("r6_data_out_reset", data_out, exp_data_out);
        do_stop();
        q = {};
        q.push_back(8'hC3);
        xfer_write(8'h54, q, 1'b1);

        chk("rx_tx_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
